// File: rtl/ysyx_22040759_axi_arbiter_pkg.sv
// Shared constants and encodings for the IF/MEM AXI4 arbiter.
package ysyx_22040759_axi_arbiter_pkg;

  localparam int unsigned ID_W       = 4;
  localparam int unsigned IF_ID_DEF  = 0;
  localparam int unsigned MEM_ID_DEF = 1;

  localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_IF_AR  = 3'd1,
    ST_IF_R   = 3'd2,
    ST_MEM_AR = 3'd3,
    ST_MEM_R  = 3'd4,
    ST_MEM_WR = 3'd5,
    ST_MEM_B  = 3'd6
  } arb_state_e;

  typedef enum logic {
    GRANT_IF  = 1'b0,
    GRANT_MEM = 1'b1
  } grant_e;

endpackage

// File: rtl/ysyx_22040759_axi_wr_pair.sv
// AW/W issue tracker: both channels raised together, each dropped after its own handshake.
module ysyx_22040759_axi_wr_pair (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic aw_ready,
  input  logic w_ready,
  output logic aw_valid,
  output logic w_valid,
  output logic wr_done
);

  logic aw_done_q, aw_done_d;
  logic w_done_q, w_done_d;
  logic aw_hs, w_hs;

  always_comb begin
    aw_valid  = active & ~aw_done_q;
    w_valid   = active & ~w_done_q;
    aw_hs     = aw_valid & aw_ready;
    w_hs      = w_valid & w_ready;
    wr_done   = active & (aw_done_q | aw_hs) & (w_done_q | w_hs);
    // Flags self-clear on completion so the next write starts fresh.
    aw_done_d = active & (aw_done_q | aw_hs) & ~wr_done;
    w_done_d  = active & (w_done_q | w_hs) & ~wr_done;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule

// File: rtl/ysyx_22040759_axi_arbiter.sv
// Round-robin arbiter sharing one AXI4 master between fetch (IF) and load/store (MEM).
module ysyx_22040759_axi_arbiter
  import ysyx_22040759_axi_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned IF_ID  = IF_ID_DEF,
  parameter int unsigned MEM_ID = MEM_ID_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_valid,
  output logic                if_ready,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_data_read,
  input  logic                mem_valid,
  output logic                mem_ready,
  input  logic                mem_wen,
  input  logic [2:0]          mem_size,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W/8-1:0] mem_wstrb,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                axi_ar_valid,
  input  logic                axi_ar_ready,
  output logic [ADDR_W-1:0]   axi_ar_addr,
  output logic [ID_W-1:0]     axi_ar_id,
  output logic [2:0]          axi_ar_size,
  output logic [7:0]          axi_ar_len,
  output logic [1:0]          axi_ar_burst,
  input  logic                axi_r_valid,
  output logic                axi_r_ready,
  input  logic [DATA_W-1:0]   axi_r_data,
  input  logic [1:0]          axi_r_resp,
  input  logic [ID_W-1:0]     axi_r_id,
  input  logic                axi_r_last,
  output logic                axi_aw_valid,
  input  logic                axi_aw_ready,
  output logic [ADDR_W-1:0]   axi_aw_addr,
  output logic [ID_W-1:0]     axi_aw_id,
  output logic [2:0]          axi_aw_size,
  output logic [7:0]          axi_aw_len,
  output logic [1:0]          axi_aw_burst,
  output logic                axi_w_valid,
  input  logic                axi_w_ready,
  output logic [DATA_W-1:0]   axi_w_data,
  output logic [DATA_W/8-1:0] axi_w_strb,
  output logic                axi_w_last,
  input  logic                axi_b_valid,
  output logic                axi_b_ready,
  input  logic [1:0]          axi_b_resp,
  input  logic [ID_W-1:0]     axi_b_id,
  output logic                bus_err
);

  arb_state_e            state_q, state_d;
  grant_e                last_grant_q, last_grant_d;
  logic                  fresh_q, fresh_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [2:0]            size_q, size_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;
  logic                  bus_err_q, bus_err_d;
  logic                  pick_if, pick_mem;
  logic                  wr_active, wr_done;

  // Single outstanding transaction, so response IDs and r_last carry no information.
  logic unused_ok;
  assign unused_ok = ^{axi_r_id, axi_r_last, axi_b_id};

  assign wr_active = (state_q == ST_MEM_WR);

  ysyx_22040759_axi_wr_pair u_wr_pair (
    .clk      (clk),
    .rst      (rst),
    .active   (wr_active),
    .aw_ready (axi_aw_ready),
    .w_ready  (axi_w_ready),
    .aw_valid (axi_aw_valid),
    .w_valid  (axi_w_valid),
    .wr_done  (wr_done)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    fresh_d      = fresh_q;
    addr_d       = addr_q;
    size_d       = size_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    bus_err_d    = bus_err_q;
    axi_ar_valid = 1'b0;
    axi_r_ready  = 1'b0;
    axi_b_ready  = 1'b0;
    if_ready     = 1'b0;
    mem_ready    = 1'b0;
    if_data_read = '0;
    mem_rdata    = '0;

    // Until the first grant after reset, IF wins a tie; afterwards the side not last granted wins.
    pick_if  = if_valid & (~mem_valid | fresh_q | (last_grant_q == GRANT_MEM));
    pick_mem = mem_valid & ~pick_if;

    case (state_q)
      ST_IDLE: begin
        if (pick_if) begin
          state_d      = ST_IF_AR;
          last_grant_d = GRANT_IF;
          fresh_d      = 1'b0;
          addr_d       = if_addr;
          size_d       = AXI_SIZE_8B;
        end else if (pick_mem) begin
          state_d      = mem_wen ? ST_MEM_WR : ST_MEM_AR;
          last_grant_d = GRANT_MEM;
          fresh_d      = 1'b0;
          addr_d       = mem_addr;
          size_d       = mem_size;
          wdata_d      = mem_wdata;
          wstrb_d      = mem_wstrb;
        end
      end
      ST_IF_AR: begin
        axi_ar_valid = 1'b1;
        if (axi_ar_ready) state_d = ST_IF_R;
      end
      ST_MEM_AR: begin
        axi_ar_valid = 1'b1;
        if (axi_ar_ready) state_d = ST_MEM_R;
      end
      ST_IF_R: begin
        axi_r_ready = 1'b1;
        if (axi_r_valid) begin
          if_ready     = 1'b1;
          if_data_read = axi_r_data;
          state_d      = ST_IDLE;
          if (axi_r_resp != AXI_RESP_OKAY) bus_err_d = 1'b1;
        end
      end
      ST_MEM_R: begin
        axi_r_ready = 1'b1;
        if (axi_r_valid) begin
          mem_ready = 1'b1;
          mem_rdata = axi_r_data;
          state_d   = ST_IDLE;
          if (axi_r_resp != AXI_RESP_OKAY) bus_err_d = 1'b1;
        end
      end
      ST_MEM_WR: begin
        if (wr_done) state_d = ST_MEM_B;
      end
      ST_MEM_B: begin
        axi_b_ready = 1'b1;
        if (axi_b_valid) begin
          mem_ready = 1'b1;
          state_d   = ST_IDLE;
          if (axi_b_resp != AXI_RESP_OKAY) bus_err_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign axi_ar_addr  = addr_q;
  assign axi_ar_id    = (last_grant_q == GRANT_IF) ? ID_W'(IF_ID) : ID_W'(MEM_ID);
  assign axi_ar_size  = size_q;
  assign axi_ar_len   = AXI_LEN_SINGLE;
  assign axi_ar_burst = AXI_BURST_INCR;
  assign axi_aw_addr  = addr_q;
  assign axi_aw_id    = ID_W'(MEM_ID);
  assign axi_aw_size  = size_q;
  assign axi_aw_len   = AXI_LEN_SINGLE;
  assign axi_aw_burst = AXI_BURST_INCR;
  assign axi_w_data   = wdata_q;
  assign axi_w_strb   = wstrb_q;
  assign axi_w_last   = 1'b1;
  assign bus_err      = bus_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GRANT_IF;
      fresh_q      <= 1'b1;
      addr_q       <= '0;
      size_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      fresh_q      <= fresh_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      bus_err_q    <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22040759_axi_arbiter.sv
// Directed bench for the IF/MEM AXI arbiter acting as a hand-driven AXI slave.
module tb_ysyx_22040759_axi_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid, if_ready;
  logic [63:0] if_addr, if_data_read;
  logic        mem_valid, mem_ready, mem_wen;
  logic [2:0]  mem_size;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wstrb;
  logic        axi_ar_valid, axi_ar_ready;
  logic [63:0] axi_ar_addr;
  logic [3:0]  axi_ar_id;
  logic [2:0]  axi_ar_size;
  logic [7:0]  axi_ar_len;
  logic [1:0]  axi_ar_burst;
  logic        axi_r_valid, axi_r_ready, axi_r_last;
  logic [63:0] axi_r_data;
  logic [1:0]  axi_r_resp;
  logic [3:0]  axi_r_id;
  logic        axi_aw_valid, axi_aw_ready;
  logic [63:0] axi_aw_addr;
  logic [3:0]  axi_aw_id;
  logic [2:0]  axi_aw_size;
  logic [7:0]  axi_aw_len;
  logic [1:0]  axi_aw_burst;
  logic        axi_w_valid, axi_w_ready, axi_w_last;
  logic [63:0] axi_w_data;
  logic [7:0]  axi_w_strb;
  logic        axi_b_valid, axi_b_ready;
  logic [1:0]  axi_b_resp;
  logic [3:0]  axi_b_id;
  logic        bus_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ysyx_22040759_axi_arbiter dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_ready(if_ready), .if_addr(if_addr), .if_data_read(if_data_read),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wen(mem_wen), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .axi_ar_valid(axi_ar_valid), .axi_ar_ready(axi_ar_ready), .axi_ar_addr(axi_ar_addr),
    .axi_ar_id(axi_ar_id), .axi_ar_size(axi_ar_size), .axi_ar_len(axi_ar_len),
    .axi_ar_burst(axi_ar_burst),
    .axi_r_valid(axi_r_valid), .axi_r_ready(axi_r_ready), .axi_r_data(axi_r_data),
    .axi_r_resp(axi_r_resp), .axi_r_id(axi_r_id), .axi_r_last(axi_r_last),
    .axi_aw_valid(axi_aw_valid), .axi_aw_ready(axi_aw_ready), .axi_aw_addr(axi_aw_addr),
    .axi_aw_id(axi_aw_id), .axi_aw_size(axi_aw_size), .axi_aw_len(axi_aw_len),
    .axi_aw_burst(axi_aw_burst),
    .axi_w_valid(axi_w_valid), .axi_w_ready(axi_w_ready), .axi_w_data(axi_w_data),
    .axi_w_strb(axi_w_strb), .axi_w_last(axi_w_last),
    .axi_b_valid(axi_b_valid), .axi_b_ready(axi_b_ready), .axi_b_resp(axi_b_resp),
    .axi_b_id(axi_b_id),
    .bus_err(bus_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Returns 2 time units after a rising edge, well clear of both clock edges.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Entered in the first *_AR cycle; returns in the IDLE cycle after completion.
  task automatic serve_read(input logic [3:0] id, input logic [63:0] addr, input logic [2:0] size,
                            input logic [63:0] data, input logic [1:0] resp);
    #1;
    chk1("ar_valid", axi_ar_valid, 1'b1);
    chk("ar_id", 64'(axi_ar_id), 64'(id));
    chk("ar_addr", axi_ar_addr, addr);
    chk("ar_size", 64'(axi_ar_size), 64'(size));
    axi_ar_ready = 1'b1;
    cyc();
    axi_ar_ready = 1'b0;
    #1;
    chk1("ar_valid_drop", axi_ar_valid, 1'b0);
    chk1("r_ready", axi_r_ready, 1'b1);
    chk1("ready_before_r", if_ready | mem_ready, 1'b0);
    axi_r_valid = 1'b1;
    axi_r_data  = data;
    axi_r_resp  = resp;
    axi_r_id    = id;
    #1;
    if (id == 4'd0) begin
      chk1("if_ready", if_ready, 1'b1);
      chk("if_data_read", if_data_read, data);
      chk1("mem_ready_quiet", mem_ready, 1'b0);
    end else begin
      chk1("mem_ready", mem_ready, 1'b1);
      chk("mem_rdata", mem_rdata, data);
      chk1("if_ready_quiet", if_ready, 1'b0);
    end
    cyc();
    axi_r_valid = 1'b0;
    axi_r_data  = 64'h0;
    axi_r_resp  = 2'b00;
    #1;
    chk1("ready_pulse_end", if_ready | mem_ready, 1'b0);
    chk1("r_ready_end", axi_r_ready, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    if_valid = 1'b0; if_addr = 64'h0;
    mem_valid = 1'b0; mem_wen = 1'b0; mem_size = 3'd0;
    mem_addr = 64'h0; mem_wdata = 64'h0; mem_wstrb = 8'h0;
    axi_ar_ready = 1'b0; axi_r_valid = 1'b0; axi_r_data = 64'h0; axi_r_resp = 2'b00;
    axi_r_id = 4'd0; axi_r_last = 1'b1;
    axi_aw_ready = 1'b0; axi_w_ready = 1'b0;
    axi_b_valid = 1'b0; axi_b_resp = 2'b00; axi_b_id = 4'd1;

    // Reset state
    repeat (2) cyc();
    #1;
    chk1("rst_ar_valid", axi_ar_valid, 1'b0);
    chk1("rst_aw_valid", axi_aw_valid, 1'b0);
    chk1("rst_w_valid", axi_w_valid, 1'b0);
    chk1("rst_r_ready", axi_r_ready, 1'b0);
    chk1("rst_b_ready", axi_b_ready, 1'b0);
    chk1("rst_if_ready", if_ready, 1'b0);
    chk1("rst_mem_ready", mem_ready, 1'b0);
    chk1("rst_bus_err", bus_err, 1'b0);
    rst = 1'b0;

    // 1: fetch only, ar_ready after two wait cycles
    if_valid = 1'b1; if_addr = 64'h8000_0000;
    cyc(); #1;
    chk1("t1_ar_valid", axi_ar_valid, 1'b1);
    chk("t1_ar_id", 64'(axi_ar_id), 64'd0);
    chk("t1_ar_size", 64'(axi_ar_size), 64'd3);
    chk("t1_ar_len", 64'(axi_ar_len), 64'd0);
    chk("t1_ar_burst", 64'(axi_ar_burst), 64'd1);
    chk("t1_ar_addr", axi_ar_addr, 64'h8000_0000);
    if_addr = 64'h1234_5678;
    cyc(); #1;
    chk1("t1_ar_wait", axi_ar_valid, 1'b1);
    chk("t1_addr_latched", axi_ar_addr, 64'h8000_0000);
    cyc();
    axi_ar_ready = 1'b1;
    cyc();
    axi_ar_ready = 1'b0;
    #1;
    chk1("t1_ar_drop", axi_ar_valid, 1'b0);
    chk1("t1_r_ready", axi_r_ready, 1'b1);
    chk1("t1_if_ready_early", if_ready, 1'b0);
    chk("t1_if_data_zero", if_data_read, 64'h0);
    axi_r_valid = 1'b1; axi_r_data = 64'h0000_0013_0010_0093;
    #1;
    chk1("t1_if_ready", if_ready, 1'b1);
    chk("t1_if_data", if_data_read, 64'h0000_0013_0010_0093);
    chk1("t1_mem_ready", mem_ready, 1'b0);
    if_valid = 1'b0;
    cyc();
    axi_r_valid = 1'b0; axi_r_data = 64'h0;
    #1;
    chk1("t1_if_ready_end", if_ready, 1'b0);
    chk("t1_if_data_end", if_data_read, 64'h0);
    chk1("t1_idle_ar", axi_ar_valid, 1'b0);

    // 2: both valid right after reset -> IF, MEM, IF
    rst = 1'b1; #1; rst = 1'b0;
    if_valid = 1'b1; if_addr = 64'h8000_0000;
    mem_valid = 1'b1; mem_wen = 1'b0; mem_addr = 64'h8000_1000; mem_size = 3'd2;
    cyc();
    serve_read(4'd0, 64'h8000_0000, 3'd3, 64'h1111_2222_3333_4444, 2'b00);
    #1;
    chk1("t2_gap_idle", axi_ar_valid, 1'b0);
    cyc();
    serve_read(4'd1, 64'h8000_1000, 3'd2, 64'h5555_6666_7777_8888, 2'b00);
    cyc();
    serve_read(4'd0, 64'h8000_0000, 3'd3, 64'h9999_AAAA_BBBB_CCCC, 2'b00);
    if_valid = 1'b0; mem_valid = 1'b0;

    // 3: store, aw_ready three cycles ahead of w_ready
    cyc();
    mem_valid = 1'b1; mem_wen = 1'b1; mem_addr = 64'h8000_2000;
    mem_wdata = 64'hDEAD_BEEF; mem_wstrb = 8'h0F; mem_size = 3'd2;
    cyc(); #1;
    chk1("t3_aw_valid", axi_aw_valid, 1'b1);
    chk1("t3_w_valid", axi_w_valid, 1'b1);
    chk("t3_aw_addr", axi_aw_addr, 64'h8000_2000);
    chk("t3_aw_id", 64'(axi_aw_id), 64'd1);
    chk("t3_aw_size", 64'(axi_aw_size), 64'd2);
    chk("t3_w_data", axi_w_data, 64'hDEAD_BEEF);
    chk("t3_w_strb", 64'(axi_w_strb), 64'h0F);
    chk1("t3_w_last", axi_w_last, 1'b1);
    chk1("t3_no_ar", axi_ar_valid, 1'b0);
    axi_aw_ready = 1'b1;
    mem_wdata = 64'hFFFF_0000_FFFF_0000;
    cyc();
    axi_aw_ready = 1'b0;
    #1;
    chk1("t3_aw_drop", axi_aw_valid, 1'b0);
    chk1("t3_w_held", axi_w_valid, 1'b1);
    chk("t3_wdata_latched", axi_w_data, 64'hDEAD_BEEF);
    cyc(); #1;
    chk1("t3_aw_stays_low", axi_aw_valid, 1'b0);
    chk1("t3_w_held2", axi_w_valid, 1'b1);
    cyc();
    axi_w_ready = 1'b1;
    #1;
    chk1("t3_w_valid_at_hs", axi_w_valid, 1'b1);
    chk1("t3_b_ready_early", axi_b_ready, 1'b0);
    cyc();
    axi_w_ready = 1'b0;
    #1;
    chk1("t3_w_drop", axi_w_valid, 1'b0);
    chk1("t3_aw_low_b", axi_aw_valid, 1'b0);
    chk1("t3_b_ready", axi_b_ready, 1'b1);
    chk1("t3_mem_ready_early", mem_ready, 1'b0);
    axi_b_valid = 1'b1;
    #1;
    chk1("t3_mem_ready", mem_ready, 1'b1);
    chk("t3_mem_rdata_zero", mem_rdata, 64'h0);
    mem_valid = 1'b0;
    cyc();
    axi_b_valid = 1'b0;
    #1;
    chk1("t3_mem_ready_end", mem_ready, 1'b0);
    chk1("t3_b_ready_end", axi_b_ready, 1'b0);
    chk1("t3_bus_err", bus_err, 1'b0);

    // 4: AW and W handshake in the same cycle
    mem_valid = 1'b1; mem_addr = 64'h8000_2008; mem_wdata = 64'h0123_4567_89AB_CDEF;
    mem_wstrb = 8'hFF; mem_size = 3'd3;
    cyc(); #1;
    chk1("t4_aw_valid", axi_aw_valid, 1'b1);
    chk1("t4_w_valid", axi_w_valid, 1'b1);
    axi_aw_ready = 1'b1; axi_w_ready = 1'b1;
    cyc();
    axi_aw_ready = 1'b0; axi_w_ready = 1'b0;
    #1;
    chk1("t4_aw_drop", axi_aw_valid, 1'b0);
    chk1("t4_w_drop", axi_w_valid, 1'b0);
    chk1("t4_b_ready", axi_b_ready, 1'b1);
    axi_b_valid = 1'b1;
    #1;
    chk1("t4_mem_ready", mem_ready, 1'b1);
    mem_valid = 1'b0;
    cyc();
    axi_b_valid = 1'b0;
    #1;
    chk1("t4_mem_ready_end", mem_ready, 1'b0);
    chk1("t4_no_dup_aw", axi_aw_valid, 1'b0);

    // 5: SLVERR on a fetch sets a sticky bus_err
    if_valid = 1'b1; if_addr = 64'h8000_0008;
    cyc();
    serve_read(4'd0, 64'h8000_0008, 3'd3, 64'hCAFE_F00D_0000_0001, 2'b10);
    if_valid = 1'b0;
    #1;
    chk1("t5_bus_err_set", bus_err, 1'b1);
    if_valid = 1'b1; if_addr = 64'h8000_0010;
    cyc();
    serve_read(4'd0, 64'h8000_0010, 3'd3, 64'h0000_0000_0000_0002, 2'b00);
    if_valid = 1'b0;
    #1;
    chk1("t5_bus_err_sticky", bus_err, 1'b1);

    // 6: reset while in MEM_R abandons the load; pending request re-granted
    mem_valid = 1'b1; mem_wen = 1'b0; mem_addr = 64'h8000_3000; mem_size = 3'd3;
    cyc(); #1;
    chk("t6_ar_id", 64'(axi_ar_id), 64'd1);
    axi_ar_ready = 1'b1;
    cyc();
    axi_ar_ready = 1'b0;
    #1;
    chk1("t6_r_ready", axi_r_ready, 1'b1);
    rst = 1'b1;
    axi_r_valid = 1'b1; axi_r_data = 64'hBAD0_BAD0_BAD0_BAD0;
    #1;
    chk1("t6_rst_r_ready", axi_r_ready, 1'b0);
    chk1("t6_rst_mem_ready", mem_ready, 1'b0);
    chk("t6_rst_mem_rdata", mem_rdata, 64'h0);
    chk1("t6_rst_ar_valid", axi_ar_valid, 1'b0);
    chk1("t6_rst_aw_valid", axi_aw_valid, 1'b0);
    chk1("t6_rst_w_valid", axi_w_valid, 1'b0);
    chk1("t6_rst_b_ready", axi_b_ready, 1'b0);
    chk1("t6_rst_bus_err", bus_err, 1'b0);
    axi_r_valid = 1'b0; axi_r_data = 64'h0;
    #1;
    rst = 1'b0;
    cyc();
    serve_read(4'd1, 64'h8000_3000, 3'd3, 64'h0000_0000_DEAD_0006, 2'b00);
    mem_valid = 1'b0;
    cyc(); #1;
    chk1("t6_final_idle", axi_ar_valid, 1'b0);
    chk1("t6_bus_err_clear", bus_err, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_22040759_axi_arbiter.md
Name: ysyx_22040759_axi_arbiter

Overview:
Shares the core's single AXI4 master port between the fetch requester (IF) and the load/store requester (MEM). It accepts one request at a time from either side and sequences a single-beat AXI read or write. It returns data and ready to the granted requester. It sits between the pipeline stages and the SoC AXI interface and is the only block driving the AXI master channels.

Parameters:
ADDR_W, 64, request/AXI address width
DATA_W, 64, data width; strobe width = DATA_W/8
IF_ID, 0, AXI ID driven on fetch reads
MEM_ID, 1, AXI ID driven on data reads/writes

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
if_valid / if_ready  in/out  1/1  fetch request hold-until-ready; if_ready is a 1-cycle completion pulse
if_addr / if_data_read  in/out  ADDR_W/DATA_W  fetch address / returned instruction data
mem_valid / mem_ready  in/out  1/1  data request hold-until-ready; mem_ready is a 1-cycle completion pulse
mem_wen / mem_size  in/in  1/3  1=write; AXI size encoding
mem_addr / mem_wdata / mem_wstrb  in  ADDR_W/DATA_W/DATA_W/8  data request fields
mem_rdata  out  DATA_W  load data, valid with mem_ready
axi_ar_valid/ready, axi_ar_addr, axi_ar_id, axi_ar_size  out/in, out, out, out  AR channel; len fixed 0, burst INCR
axi_r_valid/ready, axi_r_data, axi_r_resp, axi_r_id, axi_r_last  in/out, in, in, in, in  R channel
axi_aw_valid/ready, axi_aw_addr, axi_aw_id, axi_aw_size  out/in, out, out, out  AW channel
axi_w_valid/ready, axi_w_data, axi_w_strb, axi_w_last  out/in, out, out, out  W channel; w_last tied 1
axi_b_valid/ready, axi_b_resp, axi_b_id  in/out, in, in  B channel
bus_err  out  1  sticky, set on any nonzero r_resp/b_resp; cleared only by rst

Behaviour:
- States: IDLE, IF_AR, IF_R, MEM_AR, MEM_R, MEM_WR, MEM_B. Reset (asynchronous) forces IDLE. All AXI valid/ready outputs go to 0, if_ready=mem_ready=0, bus_err=0, and last_grant goes to IF. Reset mid-transaction abandons it without completing it.
- Grant in IDLE: only one valid -> grant it. Both valid -> grant the side not in last_grant (round-robin). last_grant is updated at grant time. Read grants take 1 cycle to enter *_AR. Request fields are latched at grant; later changes to them are ignored until completion.
- IF_AR/MEM_AR: ar_valid=1 with latched addr, the ID per requester, and size. IF size=3'b011 (8 B), MEM uses mem_size. On ar_ready -> *_R.
- *_R: r_ready=1. On r_valid, in that same cycle, drive the requester's ready=1 with data=axi_r_data combinationally, then -> IDLE. An r_id mismatch is ignored (single outstanding transaction).
- MEM_WR: aw_valid and w_valid asserted together. Per-channel done flags drop each valid independently after its handshake. When both are done -> MEM_B. Same-cycle handshake of both channels is legal.
- MEM_B: b_ready=1. On b_valid, pulse mem_ready and go to IDLE.
- The earliest regrant is the cycle after completion, so there are no back-to-back grants in the completion cycle. At most 1 outstanding AXI transaction.
- if_data_read/mem_rdata hold 0 when their ready is low.

Decomposition:
- Shared package/define file holds the state encodings, AXI size/resp/burst constants, and IF_ID/MEM_ID defaults.
- One natural sub-module is ysyx_22040759_axi_wr_pair: it owns the AW/W independent-handshake done flags and emits wr_done.

Test Plan:
1. Fetch only: if_valid=1, addr 0x80000000; slave ar_ready after 2 cycles, rdata=0x00000013_00100093 -> ar_id=0, ar_size=3, if_ready pulses 1 cycle with that data, then IDLE.
2. Simultaneous if_valid and mem_valid (load 0x80001000) after reset -> IF granted first, then MEM. With both held, grants alternate IF, MEM, IF.
3. Store addr 0x80002000, wdata 0xDEADBEEF, wstrb 0x0F; aw_ready precedes w_ready by 3 cycles -> aw_valid drops after its handshake, w_valid is held until its own, mem_ready pulses 1 cycle after b_valid.
4. aw_ready and w_ready in the same cycle -> MEM_B next cycle, no duplicate valid.
5. r_resp=2'b10 on a fetch -> if_ready still pulses, bus_err=1 and stays 1 through later OKAY transactions.
6. rst asserted asynchronously while in MEM_R -> all valids/readies 0 immediately, no mem_ready pulse; after release, a pending request is re-granted from IDLE.
